arith_arbiter: RTL and testbench
================================

// Module: arith_arbiter
// PURPOSE
//  Shares one 64-bit ripple add/sub unit between two requesters (e.g. execute ALU, address calc).
//  Accepts an operation via valid/ready, holds operands stable on the unit for SETTLE_CYCLES
//  so the gate-delay carry chain settles, captures result and flags, and returns them to the
//  granted requester as a one-cycle response pulse. Round-robin arbitration by default.
// PARAMETERS
//  WIDTH          64  datapath width; must match the add/sub unit
//  SETTLE_CYCLES  4   cycles operands are held before capture; legal range 1..15
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  req0_valid   in   1      requester 0 has an operation
//  req0_ready   out  1      requester 0 accepted this cycle when valid&ready
//  req0_a/_b    in   WIDTH  requester 0 operands
//  req0_sub     in   1      requester 0: 1 = A-B, 0 = A+B
//  req1_*       --   --     identical set for requester 1
//  rsp0_valid   out  1      one-cycle pulse: result belongs to requester 0
//  rsp1_valid   out  1      one-cycle pulse: result belongs to requester 1
//  rsp_result   out  WIDTH  captured sum/difference
//  rsp_neg/_zero/_of/_c out 1 each  result[WIDTH-1], result==0, unit overflow, unit carry
//  alu_a/_b     out  WIDTH  registered operands driven to the add/sub unit
//  alu_sub      out  1      registered subtract select to the unit
//  alu_out      in   WIDTH  unit sum; alu_of, alu_c in 1 each: unit overflow, carry flags
//  busy         out  1      high in any state other than IDLE
// BEHAVIOUR
//  States: IDLE -> SETTLE -> DONE -> IDLE. 4-bit down-counter cnt.
//  IDLE: winner picked combinationally from valids; only winner's ready=1; ready=0 outside IDLE.
//   Accept edge T0 (valid&ready): latch a/b/sub into alu_a/alu_b/alu_sub, owner<=winner,
//   cnt<=SETTLE_CYCLES-1, -> SETTLE. No valid: stay IDLE, nothing changes.
//  SETTLE: alu_* held constant regardless of req inputs; cnt decrements each cycle; at cnt==0
//   capture alu_out/alu_of/alu_c into rsp regs (edge T0+SETTLE_CYCLES), -> DONE.
//  DONE: rsp<owner>_valid=1 for exactly this cycle; other rsp_valid=0; -> IDLE.
//  Latency: rsp valid in cycle after edge T0+SETTLE_CYCLES; next accept earliest edge
//   T0+SETTLE_CYCLES+2. No response backpressure; requester must sample the pulse.
//  Arbitration: one valid -> that one wins. Both valid -> requester not granted last.
//   last_grant updated on accept; reset value 1 so req0 wins first contest.
//  rsp_result/flags hold last captured value until next capture; alu_c passed unmodified
//   (add: carry-out; sub: 1 = borrow as produced by unit).
//  Valid dropped before ready: allowed, no side effects. Valid held after accept: new op.
//  Reset (any state, incl. mid-SETTLE): state IDLE, cnt 0, last_grant 1, all outputs 0
//   (alu_*, rsp_*, ready, busy); in-flight op discarded with no response pulse.
// CONFIGURATION
//  ARITH_ARB_FIXED_PRI_EN defined: req0 always wins when both valid; last_grant ignored.
//  Undefined (default): round-robin as above.
// TESTING
//  1 reset; req0 A=5 B=3 sub=0 -> ready0 same cycle, rsp0_valid exactly SETTLE_CYCLES+1
//    cycles after accept, result 8, neg/zero/of=0; change req0_a during SETTLE -> alu_a stays 5.
//  2 req1 A=3 B=5 sub=1 -> rsp1_valid, result 0xFFFF_FFFF_FFFF_FFFE, neg=1, c=1, of=0.
//  3 req0 A=0x7FFF_FFFF_FFFF_FFFF B=1 sub=0 -> result 0x8000_0000_0000_0000, of=1, neg=1.
//  4 req0 A=B=0x1234 sub=1 -> result 0, zero=1, neg=0, c=0.
//  5 both valid held 6 ops -> grants 0,1,0,1,0,1, each rsp on matching rsp*_valid;
//    with ARITH_ARB_FIXED_PRI_EN -> all 6 grants to req0, ready1 never high.
//  6 reset asserted 2 cycles into SETTLE -> no rsp pulse, busy=0 and alu_*=0 next cycle,
//    following req0 accepted normally with correct result.

Source files
------------

// File: rtl/arith_arbiter_if.sv
// rtl/arith_arbiter_if.sv - requester, response and add/sub-unit signals of arith_arbiter
interface arith_arbiter_if #(
   parameter int WIDTH = 64
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_sub;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_sub;
   logic             rsp0_valid;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_neg;
   logic             rsp_zero;
   logic             rsp_of;
   logic             rsp_c;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_sub;
   logic [WIDTH-1:0] alu_out;
   logic             alu_of;
   logic             alu_c;
   logic             busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      input  alu_out, alu_of, alu_c,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_result, rsp_neg, rsp_zero, rsp_of, rsp_c,
      output alu_a, alu_b, alu_sub, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      output alu_out, alu_of, alu_c,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_result, rsp_neg, rsp_zero, rsp_of, rsp_c,
      input  alu_a, alu_b, alu_sub, busy
   );
endinterface

// File: rtl/arith_arbiter.sv
// rtl/arith_arbiter.sv - two-requester arbiter around a shared multi-cycle ripple add/sub unit
// ARITH_ARB_FIXED_PRI_EN selects fixed priority (req0 wins); default is round-robin.
module arith_arbiter #(
   parameter int WIDTH         = 64,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   arith_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             last_grant_q, last_grant_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             alu_sub_q, alu_sub_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_neg_q, rsp_neg_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_of_q, rsp_of_d;
   logic             rsp_c_q, rsp_c_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic             busy_q, busy_d;

   logic             winner;
   logic             ready0;
   logic             ready1;

   // winner = 1 selects requester 1
   always_comb begin
      winner = 1'b0;
`ifdef ARITH_ARB_FIXED_PRI_EN
      winner = bus.req1_valid & ~bus.req0_valid;
`else
      if (bus.req0_valid && bus.req1_valid) begin
         winner = ~last_grant_q;
      end else begin
         winner = bus.req1_valid;
      end
`endif
      ready0 = ~reset && (state_q == IDLE) && bus.req0_valid && ~winner;
      ready1 = ~reset && (state_q == IDLE) && bus.req1_valid && winner;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sub_d    = alu_sub_q;
      rsp_result_d = rsp_result_q;
      rsp_neg_d    = rsp_neg_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_of_d     = rsp_of_q;
      rsp_c_d      = rsp_c_q;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (ready0 || ready1) begin
               alu_a_d      = winner ? bus.req1_a   : bus.req0_a;
               alu_b_d      = winner ? bus.req1_b   : bus.req0_b;
               alu_sub_d    = winner ? bus.req1_sub : bus.req0_sub;
               owner_d      = winner;
               last_grant_d = winner;
               cnt_d        = CNT_INIT;
               state_d      = SETTLE;
            end
         end
         SETTLE: begin
            // Operands stay frozen here so the carry chain sees a stable input.
            if (cnt_q == 4'd0) begin
               rsp_result_d = bus.alu_out;
               rsp_neg_d    = bus.alu_out[WIDTH-1];
               rsp_zero_d   = (bus.alu_out == '0);
               rsp_of_d     = bus.alu_of;
               rsp_c_d      = bus.alu_c;
               rsp0_valid_d = ~owner_q;
               rsp1_valid_d = owner_q;
               state_d      = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sub_q    <= 1'b0;
         rsp_result_q <= '0;
         rsp_neg_q    <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_of_q     <= 1'b0;
         rsp_c_q      <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sub_q    <= alu_sub_d;
         rsp_result_q <= rsp_result_d;
         rsp_neg_q    <= rsp_neg_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_of_q     <= rsp_of_d;
         rsp_c_q      <= rsp_c_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_sub    = alu_sub_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_neg    = rsp_neg_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_of     = rsp_of_q;
   assign bus.rsp_c      = rsp_c_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_arith_arbiter.sv
// tb/tb_arith_arbiter.sv - directed self-checking bench for arith_arbiter
module tb_arith_arbiter;
   localparam int W = 64;
   localparam int S = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   arith_arbiter_if #(.WIDTH(W)) bus ();

   arith_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ripple add/sub unit: carry on add, borrow on subtract.
   logic [W:0] alu_t;
   always_comb begin
      if (bus.alu_sub) alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      else             alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      bus.alu_out = alu_t[W-1:0];
      bus.alu_c   = alu_t[W];
      if (bus.alu_sub)
         bus.alu_of = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (alu_t[W-1] != bus.alu_a[W-1]);
      else
         bus.alu_of = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (alu_t[W-1] != bus.alu_a[W-1]);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one op from requester r and returns what the DUT produced.
   task automatic run_op(input bit r, input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output bit rdy, output int lat, output bit v0, output bit v1,
                         output logic [W-1:0] res, output logic [3:0] fl);
      if (r == 1'b0) begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = s;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = s;
      end
      #1;
      rdy = r ? bus.req1_ready : bus.req0_ready;
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      lat = -1; v0 = 1'b0; v1 = 1'b0; res = '0; fl = 4'h0;
      for (int k = 1; k <= 20; k++) begin
         if (bus.rsp0_valid || bus.rsp1_valid) begin
            lat = k;
            v0  = bus.rsp0_valid;
            v1  = bus.rsp1_valid;
            res = bus.rsp_result;
            fl  = {bus.rsp_neg, bus.rsp_zero, bus.rsp_of, bus.rsp_c};
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.req0_valid = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.req0_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %0b expected 0", bus.req0_ready);
      end
      n_checks++;
      if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.alu_sub} !== 4'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
                            {bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.alu_sub});
      end
      n_checks++;
      if ({bus.alu_a, bus.alu_b, bus.rsp_result} !== {(3*W){1'b0}}) begin
         n_fail++; $display("FAIL reset_data: got %h/%h/%h expected 0", bus.alu_a, bus.alu_b,
                            bus.rsp_result);
      end
      bus.req0_valid = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_add_hold;
      int  lat;
      bit  seen0;
      bit  seen1;
      bus.req0_valid = 1'b1; bus.req0_a = 64'd5; bus.req0_b = 64'd3; bus.req0_sub = 1'b0;
      #1;
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL add_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready});
      end
      tick();
      bus.req0_a = 64'd99;
      #1;
      n_checks++;
      if ({bus.busy, bus.req0_ready} !== 2'b10) begin
         n_fail++; $display("FAIL settle_busy_ready: got %b expected 10", {bus.busy, bus.req0_ready});
      end
      tick();
      bus.req0_valid = 1'b0;
      lat = -1; seen0 = 1'b0; seen1 = 1'b0;
      for (int k = 2; k <= 20; k++) begin
         if (bus.rsp0_valid || bus.rsp1_valid) begin
            lat = k; seen0 = bus.rsp0_valid; seen1 = bus.rsp1_valid;
            break;
         end
         tick();
      end
      n_checks++;
      if (lat !== S + 1) begin
         n_fail++; $display("FAIL add_latency: got %0d expected %0d", lat, S + 1);
      end
      n_checks++;
      if ({seen0, seen1} !== 2'b10) begin
         n_fail++; $display("FAIL add_owner: got %b expected 10", {seen0, seen1});
      end
      n_checks++;
      if (bus.alu_a !== 64'd5) begin
         n_fail++; $display("FAIL settle_hold_a: got %0h expected 5", bus.alu_a);
      end
      n_checks++;
      if ({bus.rsp_result, bus.rsp_neg, bus.rsp_zero, bus.rsp_of, bus.rsp_c} !== {64'd8, 4'b0000}) begin
         n_fail++; $display("FAIL add_result: got %h flags %b expected 8 flags 0000", bus.rsp_result,
                            {bus.rsp_neg, bus.rsp_zero, bus.rsp_of, bus.rsp_c});
      end
      tick();
      n_checks++;
      if ({bus.rsp0_valid, bus.busy, bus.rsp_result} !== {2'b00, 64'd8}) begin
         n_fail++; $display("FAIL pulse_end_hold: got %b %h expected 00 8",
                            {bus.rsp0_valid, bus.busy}, bus.rsp_result);
      end
   endtask

   task automatic test_flags;
      bit             rdy;
      int             lat;
      bit             v0;
      bit             v1;
      logic [W-1:0]   res;
      logic [3:0]     fl;
      run_op(1'b1, 64'd3, 64'd5, 1'b1, rdy, lat, v0, v1, res, fl);
      n_checks++;
      if ({rdy, v0, v1, res, fl} !== {3'b101, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1001}) begin
         n_fail++; $display("FAIL sub_neg: got rdy%0b v%0b%0b %h %b expected 101 fffffffffffffffe 1001",
                            rdy, v0, v1, res, fl);
      end
      tick();
      run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, rdy, lat, v0, v1, res, fl);
      n_checks++;
      if ({rdy, v0, v1, res, fl} !== {3'b110, 64'h8000_0000_0000_0000, 4'b1010}) begin
         n_fail++; $display("FAIL add_overflow: got rdy%0b v%0b%0b %h %b expected 110 8000000000000000 1010",
                            rdy, v0, v1, res, fl);
      end
      tick();
      run_op(1'b0, 64'h1234, 64'h1234, 1'b1, rdy, lat, v0, v1, res, fl);
      n_checks++;
      if ({rdy, v0, v1, res, fl} !== {3'b110, 64'h0, 4'b0100}) begin
         n_fail++; $display("FAIL sub_zero: got rdy%0b v%0b%0b %h %b expected 110 0 0100",
                            rdy, v0, v1, res, fl);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      int   waited;
      bit   exp_g;
      logic [W-1:0] exp_r;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      bus.req0_a = 64'd100; bus.req0_b = 64'd1; bus.req0_sub = 1'b0;
      bus.req1_a = 64'd200; bus.req1_b = 64'd2; bus.req1_sub = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
`ifdef ARITH_ARB_FIXED_PRI_EN
         exp_g = 1'b0;
`else
         exp_g = i[0];
`endif
         exp_r = exp_g ? 64'd198 : 64'd101;
         waited = 0;
         while (!(bus.req0_ready || bus.req1_ready) && waited < 20) begin
            tick();
            waited++;
         end
         n_checks++;
         if ({bus.req1_ready, bus.req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL grant_%0d: got %b expected %b", i,
                               {bus.req1_ready, bus.req0_ready}, exp_g ? 2'b10 : 2'b01);
         end
         if (i > 0) begin
            n_checks++;
            if (waited !== 0) begin
               n_fail++; $display("FAIL reaccept_gap_%0d: got %0d idle cycles expected 0", i, waited);
            end
         end
         tick();
         for (int k = 0; k < 20; k++) begin
            if (bus.rsp0_valid || bus.rsp1_valid) break;
            tick();
         end
         n_checks++;
         if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_result} !== {(exp_g ? 2'b10 : 2'b01), exp_r}) begin
            n_fail++; $display("FAIL rsp_%0d: got %b %0d expected %b %0d", i,
                               {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_result,
                               exp_g ? 2'b10 : 2'b01, exp_r);
         end
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_settle;
      bit             seen;
      bit             rdy;
      int             lat;
      bit             v0;
      bit             v1;
      logic [W-1:0]   res;
      logic [3:0]     fl;
      bus.req0_valid = 1'b1; bus.req0_a = 64'h2222; bus.req0_b = 64'h1111; bus.req0_sub = 1'b1;
      tick();
      bus.req0_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({bus.busy, bus.alu_sub, bus.rsp0_valid, bus.rsp1_valid, bus.alu_a, bus.alu_b}
          !== {4'b0000, 64'h0, 64'h0}) begin
         n_fail++; $display("FAIL midreset_state: got %b %h %h expected 0000 0 0",
                            {bus.busy, bus.alu_sub, bus.rsp0_valid, bus.rsp1_valid},
                            bus.alu_a, bus.alu_b);
      end
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) seen = 1'b1;
         tick();
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL midreset_no_pulse: got %0b expected 0", seen);
      end
      run_op(1'b0, 64'd7, 64'd8, 1'b0, rdy, lat, v0, v1, res, fl);
      n_checks++;
      if ({rdy, v0, v1, res, fl} !== {3'b110, 64'd15, 4'b0000} || lat !== S + 1) begin
         n_fail++; $display("FAIL after_reset_op: got rdy%0b v%0b%0b %0d %b lat%0d expected 110 15 0000 lat%0d",
                            rdy, v0, v1, res, fl, lat, S + 1);
      end
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
      tick();
      test_reset();
      test_add_hold();
      test_flags();
      test_back_to_back();
      test_reset_mid_settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
